fb_line_arbiter: RTL and testbench

- Shared line-level backing store that sits directly downstream of the L1 caches.
- Serves two l1cache requesters (port 0 and port 1) on their l2_* line interface, through round-robin arbitration, from an internal framebuffer line BRAM.
- On a line write from one port, issues a coherence invalidation of that line to the other port's L1 through its invalidate/inv_addr/invalidated handshake.

---
 rtl/fb_line_arbiter_pkg.sv | 18 +
 rtl/fb_line_bram.sv | 36 +++
 rtl/fb_line_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_fb_line_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_line_arbiter_pkg.sv
// Shared cache attribute types used by the framebuffer line arbiter and its BRAM.
package cache_attrs;

    // Line address and line payload seen on the L1 l2_* interface
    typedef logic [11:0] fb_addr_t;
    typedef logic [63:0] fb_word_t;

    // Arbiter transaction sequencing
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } fbarb_state_t;

    // Index of one of the two requesting L1 ports
    typedef logic fbarb_port_t;

endpackage

// File: rtl/fb_line_bram.sv
// Single-port framebuffer line store: 1-cycle registered read, write-first.
module fb_line_bram
    import cache_attrs::*;
#(
    parameter int DEPTH     = 2 ** $bits(fb_addr_t),
    parameter     INIT_FILE = ""
) (
    input  logic     clk,
    input  logic     en,
    input  logic     we,
    input  fb_addr_t addr,
    input  fb_word_t din,
    output fb_word_t dout
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fb_word_t         data [DEPTH];
    logic [IDX_W-1:0] idx;

    // Upper address bits beyond the array depth are dropped
    assign idx = addr[IDX_W-1:0];

    // Write-first port: a write also returns the new line on dout
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                data[idx] <= din;
                dout      <= din;
            end else begin
                dout <= data[idx];
            end
        end
    end

endmodule

// File: rtl/fb_line_arbiter.sv
// Two-port round-robin line arbiter in front of the framebuffer BRAM, with
// cross-port invalidation of lines written by the opposite L1.
module fb_line_arbiter
    import cache_attrs::*;
#(
    parameter int FB_DEPTH  = 2 ** $bits(fb_addr_t),
    parameter     INIT_FILE = ""
) (
    input  logic     clk,
    input  logic     rst,

    input  logic     p0_en,
    input  logic     p0_w,
    input  fb_addr_t p0_addr,
    input  fb_word_t p0_in,
    output fb_word_t p0_out,
    output logic     p0_ready,
    output logic     p0_invalidate,
    output fb_addr_t p0_inv_addr,
    input  logic     p0_invalidated,

    input  logic     p1_en,
    input  logic     p1_w,
    input  fb_addr_t p1_addr,
    input  fb_word_t p1_in,
    output fb_word_t p1_out,
    output logic     p1_ready,
    output logic     p1_invalidate,
    output fb_addr_t p1_inv_addr,
    input  logic     p1_invalidated
);

    // Port-indexed views of the request interfaces
    logic [1:0] en_vec;
    logic [1:0] w_vec;
    logic [1:0] inv_ack_vec;
    fb_addr_t   addr_vec [2];
    fb_word_t   in_vec   [2];

    assign en_vec      = {p1_en, p0_en};
    assign w_vec       = {p1_w, p0_w};
    assign inv_ack_vec = {p1_invalidated, p0_invalidated};
    assign addr_vec[0] = p0_addr;
    assign addr_vec[1] = p1_addr;
    assign in_vec[0]   = p0_in;
    assign in_vec[1]   = p1_in;

    // Transaction state
    fbarb_state_t state_reg, state_next;
    fbarb_port_t  gnt_reg;
    fbarb_port_t  rr_last_reg;
    logic         w_reg;
    fb_addr_t     addr_reg;
    fb_word_t     wdata_reg;

    // Per-port output state, gathered from the generate blocks
    logic [1:0]   ready_vec;
    logic [1:0]   inv_pending;
    fb_addr_t     inv_addr_vec [2];
    fb_word_t     out_vec      [2];

    // Arbitration
    logic [1:0]   elig;
    logic         grant_valid;
    fbarb_port_t  grant_port;

    fb_word_t     bram_dout;
    logic         bram_en;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            fb_addr_t inv_addr_reg;
            fb_word_t out_reg;
            logic     inv_pending_reg;
            logic     ready_reg;

            // A port that just completed sits out one IDLE cycle; a write must
            // wait until the other L1 has no invalidation outstanding and has
            // dropped its acknowledge, so invalidate requests never run together.
            assign elig[gi] = en_vec[gi] && !ready_reg &&
                              (!w_vec[gi] || (!inv_pending[1-gi] && !inv_ack_vec[1-gi]));

            // Invalidation tracker: armed by the other port's write, released by this L1's ack
            always_ff @(posedge clk) begin
                if (rst) begin
                    inv_pending_reg <= 1'b0;
                    inv_addr_reg    <= '0;
                end else if (state_reg == ACCESS && w_reg &&
                             gnt_reg == fbarb_port_t'(1 - gi)) begin
                    inv_pending_reg <= 1'b1;
                    inv_addr_reg    <= addr_reg;
                end else if (inv_ack_vec[gi]) begin
                    inv_pending_reg <= 1'b0;
                end
            end

            // Completion pulse and held read line for this port
            always_ff @(posedge clk) begin
                if (rst) begin
                    ready_reg <= 1'b0;
                    out_reg   <= '0;
                end else begin
                    ready_reg <= (state_reg == RESP) && (gnt_reg == fbarb_port_t'(gi));
                    if (state_reg == RESP && gnt_reg == fbarb_port_t'(gi) && !w_reg) begin
                        out_reg <= bram_dout;
                    end
                end
            end

            assign ready_vec[gi]    = ready_reg;
            assign inv_pending[gi]  = inv_pending_reg;
            assign inv_addr_vec[gi] = inv_addr_reg;
            assign out_vec[gi]      = out_reg;
        end
    endgenerate

    // Round-robin pick: on a tie the port that did not win last time goes first
    always_comb begin
        grant_valid = |elig;
        grant_port  = 1'b0;
        if (elig == 2'b11) begin
            grant_port = ~rr_last_reg;
        end else if (elig[1]) begin
            grant_port = 1'b1;
        end
    end

    // Next-state logic for IDLE -> ACCESS -> RESP -> IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the granted request; later changes on the port are ignored until completion
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_reg     <= 1'b0;
            rr_last_reg <= 1'b1;
            w_reg       <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
        end else if (state_reg == IDLE && grant_valid) begin
            gnt_reg     <= grant_port;
            rr_last_reg <= grant_port;
            w_reg       <= w_vec[grant_port];
            addr_reg    <= addr_vec[grant_port];
            wdata_reg   <= in_vec[grant_port];
        end
    end

    // A reset landing on the access edge also suppresses the BRAM write
    assign bram_en = (state_reg == ACCESS) && !rst;

    fb_line_bram #(
        .DEPTH     (FB_DEPTH),
        .INIT_FILE (INIT_FILE)
    ) fb_bram (
        .clk  (clk),
        .en   (bram_en),
        .we   (w_reg),
        .addr (addr_reg),
        .din  (wdata_reg),
        .dout (bram_dout)
    );

    assign p0_out        = out_vec[0];
    assign p1_out        = out_vec[1];
    assign p0_ready      = ready_vec[0];
    assign p1_ready      = ready_vec[1];
    assign p0_invalidate = inv_pending[0];
    assign p1_invalidate = inv_pending[1];
    assign p0_inv_addr   = inv_addr_vec[0];
    assign p1_inv_addr   = inv_addr_vec[1];

endmodule

// File: tb/tb_fb_line_arbiter.sv
// Directed bench for fb_line_arbiter with a completion scoreboard.
module tb_fb_line_arbiter;
    import cache_attrs::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     p0_en, p0_w, p0_ready, p0_invalidate, p0_invalidated;
    logic     p1_en, p1_w, p1_ready, p1_invalidate, p1_invalidated;
    fb_addr_t p0_addr, p1_addr, p0_inv_addr, p1_inv_addr;
    fb_word_t p0_in, p1_in, p0_out, p1_out;

    fb_line_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .p0_en          (p0_en),
        .p0_w           (p0_w),
        .p0_addr        (p0_addr),
        .p0_in          (p0_in),
        .p0_out         (p0_out),
        .p0_ready       (p0_ready),
        .p0_invalidate  (p0_invalidate),
        .p0_inv_addr    (p0_inv_addr),
        .p0_invalidated (p0_invalidated),
        .p1_en          (p1_en),
        .p1_w           (p1_w),
        .p1_addr        (p1_addr),
        .p1_in          (p1_in),
        .p1_out         (p1_out),
        .p1_ready       (p1_ready),
        .p1_invalidate  (p1_invalidate),
        .p1_inv_addr    (p1_inv_addr),
        .p1_invalidated (p1_invalidated)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cyc [2];

    typedef struct {
        logic     port;
        logic     wr;
        fb_addr_t addr;
        fb_word_t data;
    } sb_t;
    sb_t sb [$];

    localparam fb_word_t W_DEAD = 64'hDEADBEEF_CAFEF00D;
    localparam fb_word_t W_1122 = 64'h11223344_55667788;
    localparam fb_word_t W_A5A5 = 64'hA5A55A5A_0F0FF0F0;
    localparam fb_word_t W_0BAD = 64'h0BAD0BAD_12345678;
    localparam fb_word_t W_0BB0 = 64'h00BB00BB_CCDDEEFF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int p, input logic en, input logic wr, input fb_addr_t a, input fb_word_t d);
        if (p == 0) begin
            p0_en = en; p0_w = wr; p0_addr = a; p0_in = d;
        end else begin
            p1_en = en; p1_w = wr; p1_addr = a; p1_in = d;
        end
    endtask

    task automatic push(input int p, input logic wr, input fb_addr_t a, input fb_word_t d);
        sb_t e;
        e.port = 1'(p);
        e.wr   = wr;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Step until n completions are seen; each ready is matched against the queue head
    task automatic drain(input int n, input string tag);
        int got;
        got = 0;
        for (int i = 0; i < 40 && got < n; i++) begin
            step(1);
            for (int p = 0; p < 2; p++) begin
                logic     rdy;
                fb_word_t o;
                sb_t      e;
                rdy = (p == 0) ? p0_ready : p1_ready;
                o   = (p == 0) ? p0_out : p1_out;
                if (rdy) begin
                    got++;
                    done_cyc[p] = cyc;
                    drive(p, 1'b0, 1'b0, '0, '0);
                    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk({tag, "_port"}, 64'(p), 64'(e.port));
                        if (e.wr) begin
                            chk({tag, "_bram"}, dut.fb_bram.data[e.addr], e.data);
                        end else begin
                            chk({tag, "_rdata"}, o, e.data);
                        end
                        $display("txn %s: port %0d %s addr %h data %h at cycle %0d",
                                 tag, p, e.wr ? "wr" : "rd", e.addr, e.data, cyc);
                    end
                end
            end
        end
        chk({tag, "_completions"}, 64'(got), 64'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0;
        logic seen;

        rst = 1'b1;
        p0_invalidated = 1'b0;
        p1_invalidated = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        step(2);
        rst = 1'b0;

        // Reset state
        chk("rst_p0_ready", 64'(p0_ready), 64'(0));
        chk("rst_p1_ready", 64'(p1_ready), 64'(0));
        chk("rst_p0_inv", 64'(p0_invalidate), 64'(0));
        chk("rst_p1_inv", 64'(p1_invalidate), 64'(0));
        chk("rst_p0_out", p0_out, 64'(0));
        chk("rst_p1_out", p1_out, 64'(0));
        chk("rst_p0_inv_addr", 64'(p0_inv_addr), 64'(0));
        chk("rst_p1_inv_addr", 64'(p1_inv_addr), 64'(0));
        chk("rst_state", 64'(dut.state_reg), 64'(IDLE));

        // Preload line 0x123 through port 0, which invalidates it in port 1
        c0 = cyc;
        drive(0, 1'b1, 1'b1, 12'h123, W_DEAD);
        push(0, 1'b1, 12'h123, W_DEAD);
        drain(1, "preload");
        chk("preload_lat", 64'(done_cyc[0] - c0), 64'(3));
        chk("preload_p1_inv", 64'(p1_invalidate), 64'(1));
        chk("preload_p1_inv_addr", 64'(p1_inv_addr), 64'(12'h123));
        chk("preload_p0_inv", 64'(p0_invalidate), 64'(0));
        step(1);
        chk("preload_ready_pulse", 64'(p0_ready), 64'(0));
        p1_invalidated = 1'b1;
        step(1);
        chk("preload_p1_inv_clr", 64'(p1_invalidate), 64'(0));
        p1_invalidated = 1'b0;
        step(1);

        // Plain read of the preloaded line
        c0 = cyc;
        drive(0, 1'b1, 1'b0, 12'h123, '0);
        push(0, 1'b0, 12'h123, W_DEAD);
        drain(1, "read");
        chk("read_lat", 64'(done_cyc[0] - c0), 64'(3));
        chk("read_p1_inv", 64'(p1_invalidate), 64'(0));
        step(1);
        chk("read_ready_pulse", 64'(p0_ready), 64'(0));
        chk("read_out_hold", p0_out, W_DEAD);

        // Port 1 write raises an invalidation towards port 0
        c0 = cyc;
        drive(1, 1'b1, 1'b1, 12'h456, W_1122);
        push(1, 1'b1, 12'h456, W_1122);
        drain(1, "write");
        chk("write_lat", 64'(done_cyc[1] - c0), 64'(3));
        chk("write_p0_inv", 64'(p0_invalidate), 64'(1));
        chk("write_p0_inv_addr", 64'(p0_inv_addr), 64'(12'h456));
        chk("write_p1_inv", 64'(p1_invalidate), 64'(0));
        step(1);
        chk("write_ready_pulse", 64'(p1_ready), 64'(0));
        p0_invalidated = 1'b1;
        step(1);
        chk("write_p0_inv_clr", 64'(p0_invalidate), 64'(0));
        p0_invalidated = 1'b0;
        step(1);

        // Simultaneous reads from reset: port 0 first, port 1 three cycles later
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 12'h123, '0);
        drive(1, 1'b1, 1'b0, 12'h456, '0);
        push(0, 1'b0, 12'h123, W_DEAD);
        push(1, 1'b0, 12'h456, W_1122);
        drain(2, "pair");
        chk("pair_gap", 64'(done_cyc[1] - done_cyc[0]), 64'(3));
        step(1);

        // After a port 0 win, a tie goes to port 1
        drive(0, 1'b1, 1'b0, 12'h123, '0);
        push(0, 1'b0, 12'h123, W_DEAD);
        drain(1, "rr_prep");
        step(1);
        drive(0, 1'b1, 1'b0, 12'h123, '0);
        drive(1, 1'b1, 1'b0, 12'h456, '0);
        push(1, 1'b0, 12'h456, W_1122);
        push(0, 1'b0, 12'h123, W_DEAD);
        drain(2, "rr");
        chk("rr_gap", 64'(done_cyc[0] - done_cyc[1]), 64'(3));
        step(1);

        // Port 0 reads while port 1 writes the same line; port 0 defers its ack
        drive(1, 1'b1, 1'b1, 12'h456, W_A5A5);
        drive(0, 1'b1, 1'b0, 12'h456, '0);
        push(1, 1'b1, 12'h456, W_A5A5);
        push(0, 1'b0, 12'h456, W_A5A5);
        drain(2, "defer");
        chk("defer_pending", 64'(p0_invalidate), 64'(1));
        step(3);
        chk("defer_still_pending", 64'(p0_invalidate), 64'(1));
        chk("defer_inv_addr", 64'(p0_inv_addr), 64'(12'h456));

        // Second port 1 write stalls until port 0 acks and drops its ack
        drive(1, 1'b1, 1'b1, 12'h789, W_0BAD);
        drive(0, 1'b1, 1'b0, 12'h123, '0);
        push(0, 1'b0, 12'h123, W_DEAD);
        drain(1, "stall_rd");
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            seen = seen | p1_ready;
        end
        chk("stall_hold", 64'(seen), 64'(0));
        p0_invalidated = 1'b1;
        step(1);
        chk("stall_inv_clr", 64'(p0_invalidate), 64'(0));
        seen = p1_ready;
        for (int i = 0; i < 2; i++) begin
            step(1);
            seen = seen | p1_ready;
        end
        chk("stall_hold_ack", 64'(seen), 64'(0));
        chk("stall_idle", 64'(dut.state_reg), 64'(IDLE));
        p0_invalidated = 1'b0;
        c0 = cyc;
        push(1, 1'b1, 12'h789, W_0BAD);
        drain(1, "stall_wr");
        chk("stall_wr_lat", 64'(done_cyc[1] - c0), 64'(3));
        chk("stall_wr_inv_addr", 64'(p0_inv_addr), 64'(12'h789));
        step(1);

        // Reset during the access cycle of a write, with port 0 invalidation pending
        drive(0, 1'b1, 1'b1, 12'h0BB, W_0BB0);
        step(1);
        chk("rst_pre_state", 64'(dut.state_reg), 64'(ACCESS));
        chk("rst_pre_pending", 64'(p0_invalidate), 64'(1));
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        step(1);
        rst = 1'b0;
        chk("abort_state", 64'(dut.state_reg), 64'(IDLE));
        chk("abort_p0_ready", 64'(p0_ready), 64'(0));
        chk("abort_p1_ready", 64'(p1_ready), 64'(0));
        chk("abort_p0_inv", 64'(p0_invalidate), 64'(0));
        chk("abort_p1_inv", 64'(p1_invalidate), 64'(0));
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            seen = seen | p0_ready | p1_ready | p0_invalidate | p1_invalidate;
        end
        chk("abort_quiet", 64'(seen), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
